// File: rtl/lb2apb_pkg.sv
// lb2apb_pkg: shared types and constants for the local-bus to APB bridge.
//   state_t       : bridge FSM states
//   PPROT_DEFAULT : protection attributes driven on every APB transfer
package lb2apb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS,
      RESP
   } state_t;

   localparam logic [2:0] PPROT_DEFAULT = 3'b000;

endpackage : lb2apb_pkg

// File: rtl/lb2apb.sv
// lb2apb: local-bus responder that forwards each LB write or read as a single
// APB master transfer. One transfer in flight; write wins over read when both
// are requested in the same IDLE cycle.
//
// Ports
//   clk, rst                  : clock, asynchronous active-low reset
//   lb_waddr/wdata/wstrb/wen  : LB write request (held until lb_wready)
//   lb_wready                 : one-cycle write-complete pulse
//   lb_raddr/ren              : LB read request (held until lb_rvalid)
//   lb_rdata/rvalid           : read data and one-cycle read-complete pulse
//   psel..pprot               : APB initiator outputs
//   prdata/pready/pslverr     : APB completer responses
//   slverr                    : error pulse, coincident with the LB response
module lb2apb
   import lb2apb_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   localparam int STRB_W = DATA_W / 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] lb_waddr,
   input  logic [DATA_W-1:0] lb_wdata,
   input  logic [STRB_W-1:0] lb_wstrb,
   input  logic              lb_wen,
   output logic              lb_wready,
   input  logic [ADDR_W-1:0] lb_raddr,
   input  logic              lb_ren,
   output logic [DATA_W-1:0] lb_rdata,
   output logic              lb_rvalid,
   output logic              psel,
   output logic              penable,
   output logic              pwrite,
   output logic [ADDR_W-1:0] paddr,
   output logic [DATA_W-1:0] pwdata,
   output logic [STRB_W-1:0] pstrb,
   output logic [2:0]        pprot,
   input  logic [DATA_W-1:0] prdata,
   input  logic              pready,
   input  logic              pslverr,
   output logic              slverr
);

   state_t              state, state_n;
   logic                psel_n, penable_n, pwrite_n;
   logic [ADDR_W-1:0]   paddr_n;
   logic [DATA_W-1:0]   pwdata_n, lb_rdata_n;
   logic [STRB_W-1:0]   pstrb_n;
   logic                lb_wready_n, lb_rvalid_n, slverr_n;

   assign pprot = PPROT_DEFAULT;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         psel      <= 1'b0;
         penable   <= 1'b0;
         pwrite    <= 1'b0;
         paddr     <= '0;
         pwdata    <= '0;
         pstrb     <= '0;
         lb_wready <= 1'b0;
         lb_rvalid <= 1'b0;
         lb_rdata  <= '0;
         slverr    <= 1'b0;
      end else begin
         state     <= state_n;
         psel      <= psel_n;
         penable   <= penable_n;
         pwrite    <= pwrite_n;
         paddr     <= paddr_n;
         pwdata    <= pwdata_n;
         pstrb     <= pstrb_n;
         lb_wready <= lb_wready_n;
         lb_rvalid <= lb_rvalid_n;
         lb_rdata  <= lb_rdata_n;
         slverr    <= slverr_n;
      end
   end

   // Every output is registered: this block computes the value each register
   // takes at the next edge. Response pulses default low so they last exactly
   // the one RESP cycle.
   always_comb begin
      state_n     = state;
      psel_n      = psel;
      penable_n   = penable;
      pwrite_n    = pwrite;
      paddr_n     = paddr;
      pwdata_n    = pwdata;
      pstrb_n     = pstrb;
      lb_rdata_n  = lb_rdata;
      lb_wready_n = 1'b0;
      lb_rvalid_n = 1'b0;
      slverr_n    = 1'b0;

      unique case (state)
         IDLE: begin
            if (lb_wen) begin
               paddr_n  = lb_waddr;
               pwdata_n = lb_wdata;
               pstrb_n  = lb_wstrb;
               pwrite_n = 1'b1;
               psel_n   = 1'b1;
               state_n  = SETUP;
            end else if (lb_ren) begin
               paddr_n  = lb_raddr;
               pstrb_n  = '0;
               pwrite_n = 1'b0;
               psel_n   = 1'b1;
               state_n  = SETUP;
            end
         end
         SETUP: begin
            penable_n = 1'b1;
            state_n   = ACCESS;
         end
         ACCESS: begin
            if (pready) begin
               psel_n    = 1'b0;
               penable_n = 1'b0;
               slverr_n  = pslverr;
               if (pwrite) begin
                  lb_wready_n = 1'b1;
               end else begin
                  lb_rvalid_n = 1'b1;
                  lb_rdata_n  = prdata;
               end
               state_n = RESP;
            end
         end
         RESP: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

endmodule : lb2apb

// File: tb/tb_lb2apb.sv
module tb_lb2apb;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] lb_waddr, lb_wdata, lb_raddr, lb_rdata;
   logic [3:0]  lb_wstrb;
   logic        lb_wen, lb_ren, lb_wready, lb_rvalid;
   logic        psel, penable, pwrite;
   logic [31:0] paddr, pwdata, prdata;
   logic [3:0]  pstrb;
   logic [2:0]  pprot;
   logic        pready, pslverr, slverr;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   lb2apb #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst(rst),
      .lb_waddr(lb_waddr), .lb_wdata(lb_wdata), .lb_wstrb(lb_wstrb),
      .lb_wen(lb_wen), .lb_wready(lb_wready),
      .lb_raddr(lb_raddr), .lb_ren(lb_ren),
      .lb_rdata(lb_rdata), .lb_rvalid(lb_rvalid),
      .psel(psel), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
      .prdata(prdata), .pready(pready), .pslverr(pslverr), .slverr(slverr)
   );

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      int          waits;
      logic [31:0] slv_rdata;
      bit          slv_err;
      logic [3:0]  exp_pstrb;
      logic [31:0] exp_rdata;
      bit          exp_slverr;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_access(input vec_t v);
      check("acc_psel", {31'd0, psel}, 32'd1);
      check("acc_penable", {31'd0, penable}, 32'd1);
      check("acc_pwrite", {31'd0, pwrite}, {31'd0, v.wr});
      check("acc_paddr", paddr, v.addr);
      check("acc_pstrb", {28'd0, pstrb}, {28'd0, v.exp_pstrb});
      if (v.wr) check("acc_pwdata", pwdata, v.wdata);
      check("acc_no_resp", {30'd0, lb_wready, lb_rvalid}, 32'd0);
   endtask

   // Starts at a negedge with the bridge in IDLE; ends at a negedge in IDLE.
   task automatic do_xfer(input vec_t v);
      if (v.wr) begin
         lb_waddr = v.addr; lb_wdata = v.wdata; lb_wstrb = v.strb; lb_wen = 1'b1;
      end else begin
         lb_raddr = v.addr; lb_ren = 1'b1;
      end
      @(negedge clk);  // SETUP
      check("setup_psel", {31'd0, psel}, 32'd1);
      check("setup_penable", {31'd0, penable}, 32'd0);
      check("setup_pwrite", {31'd0, pwrite}, {31'd0, v.wr});
      check("setup_paddr", paddr, v.addr);
      check("setup_pstrb", {28'd0, pstrb}, {28'd0, v.exp_pstrb});
      if (v.wr) check("setup_pwdata", pwdata, v.wdata);
      @(negedge clk);  // first ACCESS cycle
      check_access(v);
      if (v.waits == 0) begin
         pready = 1'b1; prdata = v.slv_rdata; pslverr = v.slv_err;
      end
      for (int i = 0; i < v.waits; i++) begin
         @(negedge clk);
         check_access(v);
         if (i == v.waits - 1) begin
            pready = 1'b1; prdata = v.slv_rdata; pslverr = v.slv_err;
         end
      end
      @(negedge clk);  // RESP
      check("resp_wready", {31'd0, lb_wready}, {31'd0, v.wr});
      check("resp_rvalid", {31'd0, lb_rvalid}, {31'd0, !v.wr});
      check("resp_slverr", {31'd0, slverr}, {31'd0, v.exp_slverr});
      check("resp_apb_idle", {30'd0, psel, penable}, 32'd0);
      if (!v.wr) check("resp_rdata", lb_rdata, v.exp_rdata);
      pready = 1'b0; pslverr = 1'b0; prdata = 32'h0;
      if (v.wr) lb_wen = 1'b0; else lb_ren = 1'b0;
      @(negedge clk);  // IDLE
      check("post_pulses", {29'd0, lb_wready, lb_rvalid, slverr}, 32'd0);
      check("post_psel", {31'd0, psel}, 32'd0);
   endtask

   vec_t vecs[5];
   vec_t wv, rv;

   initial begin
      //          wr  addr          wdata         strb  waits slv_rdata     err  exp_strb exp_rdata     exp_err
      vecs[0] = '{1'b1, 32'h80000004, 32'hdeadbeef, 4'hF, 0,   32'h0,        1'b0, 4'hF,    32'h0,        1'b0};
      vecs[1] = '{1'b1, 32'h0000000C, 32'hcafebabe, 4'h6, 800, 32'h0,        1'b0, 4'h6,    32'h0,        1'b0};
      vecs[2] = '{1'b0, 32'h00000014, 32'h0,        4'hF, 1,   32'hc0debabe, 1'b0, 4'h0,    32'hc0debabe, 1'b0};
      vecs[3] = '{1'b0, 32'h00000008, 32'h0,        4'h0, 5,   32'hdeadbeef, 1'b1, 4'h0,    32'hdeadbeef, 1'b1};
      vecs[4] = '{1'b1, 32'h00000020, 32'h12345678, 4'h1, 2,   32'h0,        1'b1, 4'h1,    32'h0,        1'b1};

      rst = 1'b0;
      lb_waddr = '0; lb_wdata = '0; lb_wstrb = '0; lb_wen = 1'b0;
      lb_raddr = '0; lb_ren = 1'b0;
      prdata = '0; pready = 1'b0; pslverr = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_apb", {paddr[0], pwdata[0], 1'b0, psel, penable, pwrite, 26'd0}, 32'd0);
      check("rst_paddr", paddr, 32'd0);
      check("rst_pwdata", pwdata, 32'd0);
      check("rst_pstrb", {28'd0, pstrb}, 32'd0);
      check("rst_pprot", {29'd0, pprot}, 32'd0);
      check("rst_lb", {29'd0, lb_wready, lb_rvalid, slverr}, 32'd0);
      check("rst_rdata", lb_rdata, 32'd0);
      rst = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 5; i++) do_xfer(vecs[i]);

      // Write and read raised together: write first, read right after.
      wv = '{1'b1, 32'h00000010, 32'h0badf00d, 4'hF, 0, 32'h0, 1'b0, 4'hF, 32'h0, 1'b0};
      rv = '{1'b0, 32'h00000014, 32'h0, 4'h0, 0, 32'h55aa33cc, 1'b0, 4'h0, 32'h55aa33cc, 1'b0};
      lb_raddr = rv.addr; lb_ren = 1'b1;
      do_xfer(wv);
      do_xfer(rv);
      check("idle_after_pair", {30'd0, psel, penable}, 32'd0);

      // Reset while the APB transfer is stalled in ACCESS.
      lb_waddr = 32'h00000040; lb_wdata = 32'h11112222; lb_wstrb = 4'hF; lb_wen = 1'b1;
      repeat (3) @(negedge clk);
      check("pre_rst_access", {30'd0, psel, penable}, 32'd3);
      rst = 1'b0;
      #1;
      check("midrst_apb", {30'd0, psel, penable}, 32'd0);
      check("midrst_lb", {29'd0, lb_wready, lb_rvalid, slverr}, 32'd0);
      lb_wen = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("no_stale_resp", {27'd0, psel, penable, lb_wready, lb_rvalid, slverr}, 32'd0);
      end
      wv = '{1'b1, 32'h00000004, 32'ha5a5a5a5, 4'hF, 0, 32'h0, 1'b0, 4'hF, 32'h0, 1'b0};
      do_xfer(wv);
      check("final_pprot", {29'd0, pprot}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_lb2apb
